// File: rtl/cache_pkg.sv
// Shared widths and state/mode encodings for the data cache write-back path.
// Constants only; no logic, no latency.
package cache_pkg;

    localparam int INDEX_W = 4;
    localparam int TAG_W   = 26;
    localparam int OFF_W   = 2;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = TAG_W + INDEX_W + OFF_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        EVAL = 3'd2,
        WB   = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } wb_state_t;

    typedef enum logic {
        ALL = 1'b0,
        ONE = 1'b1
    } mode_t;

endpackage

// File: rtl/cache_addr_encode.sv
// Rebuilds a word address from a stored tag and set index (inverse of the address decode).
// Purely combinational, zero latency; no flow control.
module cache_addr_encode
    import cache_pkg::*;
(
    input  logic [TAG_W-1:0]   iTag,
    input  logic [INDEX_W-1:0] iIndex,
    output logic [ADDR_W-1:0]  oAddress
);

    assign oAddress = {iTag, iIndex, {OFF_W{1'b0}}};

endmodule

// File: rtl/cache_writeback_ctrl.sv
// Walks cache sets (all on flush, one on evict) and writes dirty valid lines back to memory.
// 3 cycles per clean set, 4+stall per dirty set; stalls in WB for as long as iWbReady is low.
module cache_writeback_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               iFlushStart,
    input  logic               iEvictReq,
    input  logic [INDEX_W-1:0] iEvictIndex,
    output logic [INDEX_W-1:0] oSetIndex,
    input  logic               iLineValid,
    input  logic               iLineDirty,
    input  logic [TAG_W-1:0]   iLineTag,
    input  logic [DATA_W-1:0]  iLineData,
    output logic               oWbValid,
    output logic [ADDR_W-1:0]  oWbAddress,
    output logic [DATA_W-1:0]  oWbData,
    input  logic               iWbReady,
    output logic               oCleanValid,
    output logic [INDEX_W-1:0] oCleanIndex,
    output logic               oBusy,
    output logic               oDone,
    output logic [INDEX_W:0]   oWbCount
);

    localparam logic [INDEX_W-1:0] IDX_ONE = INDEX_W'(1);
    localparam logic [INDEX_W:0]   CNT_ONE = (INDEX_W + 1)'(1);

    wb_state_t          state;
    mode_t              mode;
    logic [INDEX_W-1:0] idx;
    logic [INDEX_W:0]   count;
    logic               wrote;
    logic [TAG_W-1:0]   tag_q;
    logic [DATA_W-1:0]  data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode   <= ALL;
            idx    <= '0;
            count  <= '0;
            wrote  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wrote <= 1'b0;
                    // Flush has priority; a simultaneous evict is simply dropped.
                    if (iFlushStart) begin
                        idx   <= '0;
                        mode  <= ALL;
                        count <= '0;
                        state <= RD;
                    end else if (iEvictReq) begin
                        idx   <= iEvictIndex;
                        mode  <= ONE;
                        count <= '0;
                        state <= RD;
                    end
                end
                RD: state <= EVAL;
                EVAL: begin
                    tag_q  <= iLineTag;
                    data_q <= iLineData;
                    if (iLineValid && iLineDirty) begin
                        state <= WB;
                    end else begin
                        wrote <= 1'b0;
                        state <= NEXT;
                    end
                end
                WB: begin
                    if (iWbReady) begin
                        count <= count + CNT_ONE;
                        wrote <= 1'b1;
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    wrote <= 1'b0;
                    // Last-set test precedes the increment so idx stops at the top set.
                    if (mode == ONE || idx == '1) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + IDX_ONE;
                        state <= RD;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    cache_addr_encode u_addr_encode (
        .iTag     (tag_q),
        .iIndex   (idx),
        .oAddress (oWbAddress)
    );

    assign oSetIndex   = idx;
    assign oWbValid    = (state == WB);
    assign oWbData     = data_q;
    assign oCleanValid = (state == NEXT) && wrote;
    assign oCleanIndex = idx;
    assign oBusy       = (state != IDLE);
    assign oDone       = (state == DONE);
    assign oWbCount    = count;

endmodule

// File: tb/tb_cache_writeback_ctrl.sv
// Directed scoreboard bench for cache_writeback_ctrl with a registered cache-array model.
module tb_cache_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iFlushStart;
    logic        iEvictReq;
    logic [3:0]  iEvictIndex;
    logic [3:0]  oSetIndex;
    logic        iLineValid;
    logic        iLineDirty;
    logic [25:0] iLineTag;
    logic [31:0] iLineData;
    logic        oWbValid;
    logic [31:0] oWbAddress;
    logic [31:0] oWbData;
    logic        iWbReady = 1'b1;
    logic        oCleanValid;
    logic [3:0]  oCleanIndex;
    logic        oBusy;
    logic        oDone;
    logic [4:0]  oWbCount;

    always #5 clk = ~clk;

    cache_writeback_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iFlushStart (iFlushStart),
        .iEvictReq   (iEvictReq),
        .iEvictIndex (iEvictIndex),
        .oSetIndex   (oSetIndex),
        .iLineValid  (iLineValid),
        .iLineDirty  (iLineDirty),
        .iLineTag    (iLineTag),
        .iLineData   (iLineData),
        .oWbValid    (oWbValid),
        .oWbAddress  (oWbAddress),
        .oWbData     (oWbData),
        .iWbReady    (iWbReady),
        .oCleanValid (oCleanValid),
        .oCleanIndex (oCleanIndex),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oWbCount    (oWbCount)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [3:0]  exp_clean_q[$];
    logic [4:0]  exp_cnt_q[$];
    int          exp_busy_q[$];
    int          done_seen = 0;
    int          busy_cnt = 0;

    logic        m_valid[16];
    logic        m_dirty[16];
    logic [25:0] m_tag[16];
    logic [31:0] m_data[16];

    logic [3:0]  stall_set = 4'd0;
    int          stall_budget = 0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache arrays answer one cycle after the index is presented.
    always @(posedge clk) begin
        iLineValid <= m_valid[oSetIndex];
        iLineDirty <= m_dirty[oSetIndex];
        iLineTag   <= m_tag[oSetIndex];
        iLineData  <= m_data[oSetIndex];
    end

    always @(posedge clk) begin
        #1;
        if (!oWbValid) begin
            stall_cnt = 0;
            iWbReady  = 1'b1;
        end else if (oSetIndex == stall_set && stall_cnt < stall_budget) begin
            stall_cnt++;
            iWbReady = 1'b0;
        end else begin
            iWbReady = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (oBusy) busy_cnt++;
        else       busy_cnt = 0;
        if (oWbValid) begin
            if (exp_addr_q.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                chk("wb_address", oWbAddress, exp_addr_q[0]);
                chk("wb_data", oWbData, exp_data_q[0]);
                if (iWbReady) begin
                    void'(exp_addr_q.pop_front());
                    void'(exp_data_q.pop_front());
                end
            end
        end
        if (oCleanValid) begin
            if (exp_clean_q.size() == 0) chk("unexpected_clean", 32'd1, 32'd0);
            else chk("clean_index", 32'(oCleanIndex), 32'(exp_clean_q.pop_front()));
        end
        if (oDone) begin
            if (exp_cnt_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("wb_count", 32'(oWbCount), 32'(exp_cnt_q.pop_front()));
                chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy_q.pop_front()));
            end
            done_seen++;
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = 26'(i * 3 + 1);
            m_data[i]  = 32'hC0DE0000 | 32'(i);
        end
    endtask

    task automatic set_line(input int i, input logic v, input logic d,
                            input logic [25:0] t, input logic [31:0] dat);
        m_valid[i] = v;
        m_dirty[i] = d;
        m_tag[i]   = t;
        m_data[i]  = dat;
    endtask

    task automatic expect_wb(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ci);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
        exp_clean_q.push_back(ci);
    endtask

    task automatic expect_done(input logic [4:0] cnt, input int busy);
        exp_cnt_q.push_back(cnt);
        exp_busy_q.push_back(busy);
    endtask

    task automatic start(input logic f, input logic e, input logic [3:0] ei);
        iFlushStart = f;
        iEvictReq   = e;
        iEvictIndex = ei;
        @(posedge clk); #1;
        iFlushStart = 1'b0;
        iEvictReq   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int s = done_seen;
        int n = 0;
        while (done_seen == s && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_seen == s) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wb_valid"}, 32'(oWbValid), 32'd0);
        chk({tag, "_wb_address"}, oWbAddress, 32'd0);
        chk({tag, "_wb_data"}, oWbData, 32'd0);
        chk({tag, "_clean_valid"}, 32'(oCleanValid), 32'd0);
        chk({tag, "_clean_index"}, 32'(oCleanIndex), 32'd0);
        chk({tag, "_busy"}, 32'(oBusy), 32'd0);
        chk({tag, "_done"}, 32'(oDone), 32'd0);
        chk({tag, "_wb_count"}, 32'(oWbCount), 32'd0);
        chk({tag, "_set_index"}, 32'(oSetIndex), 32'd0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        iFlushStart = 1'b0;
        iEvictReq   = 1'b0;
        iEvictIndex = 4'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All lines invalid: 48 walk cycles plus DONE, no traffic.
        expect_done(5'd0, 49);
        start(1'b1, 1'b0, 4'd0);
        wait_done("flush_empty", 200);

        // Single dirty evict with memory always ready.
        clear_model();
        set_line(5, 1'b1, 1'b1, 26'h0ABCDEF, 32'hDEADBEEF);
        expect_wb(32'h2AF37BD4, 32'hDEADBEEF, 4'd5);
        expect_done(5'd1, 5);
        start(1'b0, 1'b1, 4'd5);
        wait_done("evict5", 50);

        // Flush with three dirty sets, 3-cycle stall on set 7.
        clear_model();
        set_line(0, 1'b1, 1'b1, 26'h0000001, 32'h11110000);
        set_line(4, 1'b1, 1'b0, 26'h0000444, 32'h44444444);
        set_line(7, 1'b1, 1'b1, 26'h3FFFFFF, 32'h77777777);
        set_line(9, 1'b0, 1'b1, 26'h0000999, 32'h99999999);
        set_line(15, 1'b1, 1'b1, 26'h1234567, 32'hFFFF0015);
        stall_set    = 4'd7;
        stall_budget = 3;
        expect_wb(32'h00000040, 32'h11110000, 4'd0);
        expect_wb(32'hFFFFFFDC, 32'h77777777, 4'd7);
        expect_wb(32'h48D159FC, 32'hFFFF0015, 4'd15);
        expect_done(5'd3, 55);
        start(1'b1, 1'b0, 4'd0);
        wait_done("flush_dirty", 300);
        stall_budget = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("no_wrap_busy", 32'(oBusy), 32'd0);
        chk("no_wrap_index", 32'(oSetIndex), 32'd15);

        // Simultaneous flush and evict: flush wins; evict while busy is ignored.
        clear_model();
        set_line(3, 1'b1, 1'b1, 26'h2000000, 32'h33333333);
        expect_wb(32'h8000000C, 32'h33333333, 4'd3);
        expect_done(5'd1, 50);
        start(1'b1, 1'b1, 4'd3);
        repeat (5) @(posedge clk);
        #1;
        start(1'b0, 1'b1, 4'd3);
        wait_done("flush_and_evict", 200);
        repeat (20) @(posedge clk);
        #1;
        chk("ignored_evict_busy", 32'(oBusy), 32'd0);

        // Reset during an indefinite stall on set 7.
        clear_model();
        set_line(0, 1'b1, 1'b1, 26'h0000001, 32'h11110000);
        set_line(7, 1'b1, 1'b1, 26'h3FFFFFF, 32'h77777777);
        set_line(15, 1'b1, 1'b1, 26'h1234567, 32'hFFFF0015);
        stall_set    = 4'd7;
        stall_budget = 1000;
        expect_wb(32'h00000040, 32'h11110000, 4'd0);
        expect_wb(32'hFFFFFFDC, 32'h77777777, 4'd7);
        start(1'b1, 1'b0, 4'd0);
        n = 0;
        while (!(oWbValid && oSetIndex == 4'd7) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_stall_set7", 32'(oWbValid && oSetIndex == 4'd7), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        chk("midreset_pending_wb", 32'(exp_addr_q.size()), 32'd1);
        chk("midreset_pending_clean", 32'(exp_clean_q.size()), 32'd1);
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_clean_q.delete();
        rst_n        = 1'b1;
        stall_budget = 0;
        m_dirty[0]   = 1'b0;
        @(posedge clk); #1;
        expect_wb(32'hFFFFFFDC, 32'h77777777, 4'd7);
        expect_wb(32'h48D159FC, 32'hFFFF0015, 4'd15);
        expect_done(5'd2, 51);
        start(1'b1, 1'b0, 4'd0);
        wait_done("flush_after_reset", 300);

        // Valid but clean line at the evict index.
        clear_model();
        set_line(10, 1'b1, 1'b0, 26'h0AAAAAA, 32'hAAAA5555);
        expect_done(5'd0, 4);
        start(1'b0, 1'b1, 4'd10);
        wait_done("evict_clean", 50);

        repeat (5) @(posedge clk);
        #1;
        chk("leftover_wb", 32'(exp_addr_q.size()), 32'd0);
        chk("leftover_clean", 32'(exp_clean_q.size()), 32'd0);
        chk("leftover_done", 32'(exp_cnt_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_writeback_ctrl.md
# cache_writeback_ctrl

Write-back/flush sequencer for the 16-set direct-mapped data cache. It walks cache sets, either all of them on a flush or one on an eviction. For each valid and dirty line it rebuilds the word address from the stored tag and set index, {tag, index, 2'b00}, which is the inverse of the cache address decode. It then hands that line to main memory over a valid/ready channel and tells the cache array to clear the line's dirty bit. It sits between the cache tag/data arrays and the memory write port.

## Interface
- INDEX_W, 4, set index width (16 sets)
- TAG_W, 26, stored tag width
- OFF_W, 2, byte offset width; address = TAG_W+INDEX_W+OFF_W = 32
- DATA_W, 32, line (word) width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset; synchronous, active-low
- iFlushStart  in  1  start a full flush of sets 0..15 (sampled in IDLE only)
- iEvictReq  in  1  write back a single set (sampled in IDLE only)
- iEvictIndex  in  INDEX_W  set to evict; captured with iEvictReq
- oSetIndex  out  INDEX_W  read index to cache arrays; array data arrives the following cycle
- iLineValid, iLineDirty  in  1 each  status of the line at the previous cycle's oSetIndex
- iLineTag  in  TAG_W  stored tag of that line
- iLineData  in  DATA_W  stored data of that line
- oWbValid  out  1  write-back request valid
- oWbAddress  out  32  {tag, index, 2'b00}
- oWbData  out  DATA_W  line data
- iWbReady  in  1  memory accepts; a transfer happens when oWbValid & iWbReady at the edge
- oCleanValid  out  1  one-cycle pulse: clear the dirty bit at oCleanIndex
- oCleanIndex  out  INDEX_W  set to clean
- oBusy  out  1  high in every state except IDLE
- oDone  out  1  one-cycle pulse at the end of the operation
- oWbCount  out  INDEX_W+1  number of lines written back by the last operation; held until the next start

## Operation
- States: IDLE, RD, EVAL, WB, NEXT, DONE.
- IDLE
  - iFlushStart: idx<=0, mode<=ALL, count<=0, go to RD.
  - else iEvictReq: idx<=iEvictIndex, mode<=ONE, count<=0, go to RD.
  - If both are high, flush wins and the evict request is dropped.
- RD: oSetIndex=idx (oSetIndex always equals the idx register). Always go to EVAL.
- EVAL: register tag, data and the dirty&valid result. If valid&dirty, go to WB; else go to NEXT with wrote=0.
- WB
  - oWbValid=1.
  - oWbAddress/oWbData are driven from registers and stay stable until the handshake.
  - On handshake: count++, wrote<=1, go to NEXT.
  - With iWbReady low, the block stalls indefinitely with no timeout.
- NEXT
  - oCleanValid=wrote, oCleanIndex=idx.
  - If mode==ONE or idx==all-ones, go to DONE; else idx<=idx+1, go to RD.
  - The last-set check is made before the increment; idx never wraps to 0.
- DONE: oDone=1, go to IDLE.
- Requests arriving while oBusy is high are ignored, not queued.
- Invalid lines and clean valid lines produce no memory traffic and no clean pulse.

## Timing
- Reset values: state IDLE, idx 0, oWbValid 0, oWbAddress 0, oWbData 0, oCleanValid 0, oCleanIndex 0, oBusy 0, oDone 0, oWbCount 0.
- Reset mid-operation: on the next edge the block returns to IDLE with all outputs at their reset values. oWbValid drops even if no handshake has occurred. No clean pulse is issued.
- Per set: 3 cycles if clean (RD, EVAL, NEXT); 4+N cycles if dirty, with N = cycles iWbReady is low in WB.
- Full flush of an all-clean cache: start edge, then 48 cycles, then 1 DONE cycle; oBusy is high for 49 cycles.
- Single dirty evict with iWbReady tied high: oBusy is high for 5 cycles (RD, EVAL, WB, NEXT, DONE).
- oCleanValid is asserted the cycle after the WB handshake, never in the same cycle.

## Structure
- Shared package cache_pkg holds:
  - INDEX_W, TAG_W, OFF_W and DATA_W constants;
  - the wb_state_t enum (IDLE..DONE);
  - the mode_t enum (ALL, ONE).
- Sub-module cache_addr_encode: combinational; {iTag, iIndex, OFF_W'b0} gives oAddress. It is the inverse of the address decode and is reused by the fill path.

## Test plan
- Reset, then iFlushStart with all lines invalid → no oWbValid, oDone exactly 49 cycles after the start edge, oWbCount=0.
- Evict set 5 (tag 0x0ABCDEF, data 0xDEADBEEF, valid, dirty, iWbReady=1) → oWbAddress=0x2AF37BD4, oWbData=0xDEADBEEF, then oCleanValid with oCleanIndex=5, oWbCount=1.
- Flush with sets 0, 7 and 15 dirty, iWbReady held low for 3 cycles on set 7 → three transfers in index order. Address and data stay stable through the stall. Three clean pulses, oWbCount=3, no wrap past set 15.
- iFlushStart and iEvictReq in the same cycle → full flush runs; a second iEvictReq while busy is ignored.
- rst_n low during the WB stall on set 7 → outputs return to reset values on the next edge; a new flush then completes normally.
- Valid but clean line at an evict index → no oWbValid, no oCleanValid, oDone after 4 busy cycles.
